// File: rtl/max_score_tracker_pkg.sv
// Shared definitions for the alignment score tracker: matrix geometry,
// score/source widths, the tracker FSM encoding and PE source codes.
package design_variables;

    localparam int SCORE_WIDTH  = 10;
    localparam int SOURCE_WIDTH = 2;
    localparam int QUERY_LEN    = 32;
    localparam int DATABASE_LEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } tracker_state_t;

    // Traceback source codes produced by the processing element.
    localparam logic [SOURCE_WIDTH-1:0] SRC_NONE = 2'd0;
    localparam logic [SOURCE_WIDTH-1:0] SRC_DIAG = 2'd1;
    localparam logic [SOURCE_WIDTH-1:0] SRC_UP   = 2'd2;
    localparam logic [SOURCE_WIDTH-1:0] SRC_LEFT = 2'd3;

endpackage

// File: rtl/max_score_tracker_cell_index_counter.sv
// Raster-order (row, col) cell counter with clear, increment and a flag
// marking the final cell of the matrix.
module cell_index_counter #(
    parameter int QUERY_LEN    = 32,
    parameter int DATABASE_LEN = 32,
    parameter int ROW_WIDTH    = $clog2(QUERY_LEN),
    parameter int COL_WIDTH    = $clog2(DATABASE_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [ROW_WIDTH-1:0] row,
    output logic [COL_WIDTH-1:0] col,
    output logic                 last
);

    logic [ROW_WIDTH-1:0] row_r;
    logic [COL_WIDTH-1:0] col_r;
    logic                 col_end_s;

    assign col_end_s = (col_r == COL_WIDTH'(DATABASE_LEN - 1));
    assign last      = col_end_s && (row_r == ROW_WIDTH'(QUERY_LEN - 1));
    assign row       = row_r;
    assign col       = col_r;

    // Advance column, wrapping into the next row at the end of each row.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r <= {ROW_WIDTH{1'b0}};
            col_r <= {COL_WIDTH{1'b0}};
        end else if (clear) begin
            row_r <= {ROW_WIDTH{1'b0}};
            col_r <= {COL_WIDTH{1'b0}};
        end else if (inc) begin
            if (col_end_s) begin
                col_r <= {COL_WIDTH{1'b0}};
                row_r <= last ? {ROW_WIDTH{1'b0}} : row_r + ROW_WIDTH'(1);
            end else begin
                col_r <= col_r + COL_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/max_score_tracker.sv
// Tracks the best cell score and its coordinates over a raster-ordered
// matrix and writes each cell's traceback entry. Optional TB_ZERO_FLAG_EN.
module max_score_tracker
    import design_variables::*;
#(
    parameter int SCORE_WIDTH_P  = SCORE_WIDTH,
    parameter int SOURCE_WIDTH_P = SOURCE_WIDTH,
    parameter int QUERY_LEN_P    = QUERY_LEN,
    parameter int DATABASE_LEN_P = DATABASE_LEN,
    parameter int ROW_WIDTH      = $clog2(QUERY_LEN_P),
    parameter int COL_WIDTH      = $clog2(DATABASE_LEN_P),
    parameter int ADDR_WIDTH     = ROW_WIDTH + COL_WIDTH,
`ifdef TB_ZERO_FLAG_EN
    parameter int TB_DATA_WIDTH  = SOURCE_WIDTH_P + 1
`else
    parameter int TB_DATA_WIDTH  = SOURCE_WIDTH_P
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pe_valid,
    input  logic [SCORE_WIDTH_P-1:0]  pe_score,
    input  logic [SOURCE_WIDTH_P-1:0] pe_source,
    input  logic                      pe_zero,
    output logic                      busy,
    output logic                      done,
    output logic [SCORE_WIDTH_P-1:0]  max_score,
    output logic [ROW_WIDTH-1:0]      max_row,
    output logic [COL_WIDTH-1:0]      max_col,
    output logic                      max_found,
    output logic                      tb_wr_en,
    output logic [ADDR_WIDTH-1:0]     tb_wr_addr,
    output logic [TB_DATA_WIDTH-1:0]  tb_wr_data
);

    tracker_state_t             state_r;
    tracker_state_t             next_state_s;
    logic                       clear_s;
    logic                       consume_s;
    logic                       last_s;
    logic [ROW_WIDTH-1:0]       row_s;
    logic [COL_WIDTH-1:0]       col_s;
    logic [TB_DATA_WIDTH-1:0]   entry_s;
    logic                       busy_r;
    logic                       done_r;
    logic [SCORE_WIDTH_P-1:0]   max_score_r;
    logic [ROW_WIDTH-1:0]       max_row_r;
    logic [COL_WIDTH-1:0]       max_col_r;
    logic                       max_found_r;
    logic                       tb_wr_en_r;
    logic [ADDR_WIDTH-1:0]      tb_wr_addr_r;
    logic [TB_DATA_WIDTH-1:0]   tb_wr_data_r;

    assign consume_s = (state_r == TRACK) && pe_valid;

`ifdef TB_ZERO_FLAG_EN
    assign entry_s = {pe_zero, pe_source};
`else
    assign entry_s = pe_source;
`endif

    cell_index_counter #(
        .QUERY_LEN    (QUERY_LEN_P),
        .DATABASE_LEN (DATABASE_LEN_P),
        .ROW_WIDTH    (ROW_WIDTH),
        .COL_WIDTH    (COL_WIDTH)
    ) u_index (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .inc   (consume_s),
        .row   (row_s),
        .col   (col_s),
        .last  (last_s)
    );

    // Next-state logic; a start accepted in IDLE also clears the tracker.
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    clear_s      = 1'b1;
                    next_state_s = TRACK;
                end else begin
                    next_state_s = IDLE;
                end
            end
            TRACK: begin
                if (consume_s && last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = TRACK;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register with busy/done decoded one cycle early so they are flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == TRACK);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Best-score tracking; strict compare keeps the earliest cell on ties.
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            max_score_r <= {SCORE_WIDTH_P{1'b0}};
            max_row_r   <= {ROW_WIDTH{1'b0}};
            max_col_r   <= {COL_WIDTH{1'b0}};
            max_found_r <= 1'b0;
        end else if (consume_s) begin
            if (pe_score > max_score_r) begin
                max_score_r <= pe_score;
                max_row_r   <= row_s;
                max_col_r   <= col_s;
            end
            if (!pe_zero) begin
                max_found_r <= 1'b1;
            end
        end
    end

    // Traceback write port, one registered write per consumed cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            tb_wr_en_r   <= 1'b0;
            tb_wr_addr_r <= {ADDR_WIDTH{1'b0}};
            tb_wr_data_r <= {TB_DATA_WIDTH{1'b0}};
        end else begin
            tb_wr_en_r <= consume_s;
            if (consume_s) begin
                tb_wr_addr_r <= {row_s, col_s};
                tb_wr_data_r <= entry_s;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign max_score  = max_score_r;
    assign max_row    = max_row_r;
    assign max_col    = max_col_r;
    assign max_found  = max_found_r;
    assign tb_wr_en   = tb_wr_en_r;
    assign tb_wr_addr = tb_wr_addr_r;
    assign tb_wr_data = tb_wr_data_r;

endmodule

// File: tb/tb_max_score_tracker.sv
// Scoreboard bench for max_score_tracker: random matrices against a
// raster-order running-maximum model and an expected-write queue.
module tb_max_score_tracker;
    import design_variables::*;

    localparam int RW    = $clog2(QUERY_LEN);
    localparam int CW    = $clog2(DATABASE_LEN);
    localparam int AW    = RW + CW;
    localparam int NCELL = QUERY_LEN * DATABASE_LEN;
`ifdef TB_ZERO_FLAG_EN
    localparam int DW = SOURCE_WIDTH + 1;
`else
    localparam int DW = SOURCE_WIDTH;
`endif

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    pe_valid;
    logic [SCORE_WIDTH-1:0]  pe_score;
    logic [SOURCE_WIDTH-1:0] pe_source;
    logic                    pe_zero;
    logic                    busy;
    logic                    done;
    logic [SCORE_WIDTH-1:0]  max_score;
    logic [RW-1:0]           max_row;
    logic [CW-1:0]           max_col;
    logic                    max_found;
    logic                    tb_wr_en;
    logic [AW-1:0]           tb_wr_addr;
    logic [DW-1:0]           tb_wr_data;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  errors;
    int  checks;
    int  done_cnt;
    int  scr[NCELL];
    bit  zr[NCELL];

    max_score_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pe_valid   (pe_valid),
        .pe_score   (pe_score),
        .pe_source  (pe_source),
        .pe_zero    (pe_zero),
        .busy       (busy),
        .done       (done),
        .max_score  (max_score),
        .max_row    (max_row),
        .max_col    (max_col),
        .max_found  (max_found),
        .tb_wr_en   (tb_wr_en),
        .tb_wr_addr (tb_wr_addr),
        .tb_wr_data (tb_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: count done pulses and match every write against the queue.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (tb_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d expected no write", int'(tb_wr_addr));
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", int'(tb_wr_addr), mon_e.addr);
                chk("wr_data", int'(tb_wr_data), mon_e.data);
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_max_score"}, int'(max_score), 0);
        chk({tag, "_max_row"}, int'(max_row), 0);
        chk({tag, "_max_col"}, int'(max_col), 0);
        chk({tag, "_max_found"}, int'(max_found), 0);
        chk({tag, "_wr_en"}, int'(tb_wr_en), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_max_score", int'(max_score), 0);
        chk("start_max_found", int'(max_found), 0);
    endtask

    // Feed the matrix in raster order; abort_after>0 stops after that many cells.
    task automatic feed(input bit gaps, input int abort_after);
        int best, br, bc, k, r, c, d0, src;
        bit found;
        wr_t e;
        best = 0; br = 0; bc = 0; found = 1'b0; k = 0; d0 = done_cnt;
        while (k < NCELL) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                pe_valid  = 1'b0;
                pe_score  = SCORE_WIDTH'($urandom);
                pe_source = SOURCE_WIDTH'($urandom);
                pe_zero   = 1'b0;
                @(posedge clk); #1;
                chk("gap_busy", int'(busy), 1);
            end else begin
                r = k / DATABASE_LEN;
                c = k % DATABASE_LEN;
                src = (r + c) % 4;
                pe_valid  = 1'b1;
                pe_score  = SCORE_WIDTH'(scr[k]);
                pe_source = SOURCE_WIDTH'(src);
                pe_zero   = zr[k];
                e.addr = r * DATABASE_LEN + c;
`ifdef TB_ZERO_FLAG_EN
                e.data = (int'(zr[k]) << SOURCE_WIDTH) + src;
`else
                e.data = src;
`endif
                exp_q.push_back(e);
                @(posedge clk); #1;
                if (scr[k] > best) begin
                    best = scr[k]; br = r; bc = c;
                end
                if (!zr[k]) found = 1'b1;
                chk("run_max_score", int'(max_score), best);
                chk("run_max_row", int'(max_row), br);
                chk("run_max_col", int'(max_col), bc);
                chk("run_max_found", int'(max_found), int'(found));
                chk("run_done", int'(done), int'(k == NCELL - 1));
                k++;
                if (k == abort_after) begin
                    pe_valid = 1'b0;
                    return;
                end
            end
        end
        pe_valid = 1'b1;
        pe_score = SCORE_WIDTH'(1023);
        pe_zero  = 1'b0;
        @(posedge clk); #1;
        pe_valid = 1'b0;
        chk("post_done", int'(done), 0);
        chk("post_busy", int'(busy), 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("hold_max_score", int'(max_score), best);
        chk("hold_max_row", int'(max_row), br);
        chk("hold_max_col", int'(max_col), bc);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0; checks = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; pe_valid = 1'b0;
        pe_score = '0; pe_source = '0; pe_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("reset");

        // pe_valid outside TRACK must be ignored
        pe_valid = 1'b1; pe_score = SCORE_WIDTH'(50); pe_zero = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_max_score", int'(max_score), 0);
            chk("idle_wr_en", int'(tb_wr_en), 0);
            chk("idle_max_found", int'(max_found), 0);
        end
        pe_valid = 1'b0;

        // all-zero matrix
        for (int k = 0; k < NCELL; k++) begin scr[k] = 0; zr[k] = 1'b1; end
        do_start();
        feed(1'b0, -1);
        chk("zero_max_found", int'(max_found), 0);

        // ramp with a tie at 77
        for (int k = 0; k < NCELL; k++) begin
            scr[k] = 1 + ((k / DATABASE_LEN + k % DATABASE_LEN) % 60);
            zr[k] = 1'b0;
        end
        scr[5 * DATABASE_LEN + 9] = 77;
        scr[20 * DATABASE_LEN + 3] = 77;
        do_start();
        feed(1'b0, -1);
        chk("tie_max_score", int'(max_score), 77);
        chk("tie_max_row", int'(max_row), 5);
        chk("tie_max_col", int'(max_col), 9);
        chk("tie_max_found", int'(max_found), 1);

        // random scores with zeros and random gaps
        for (int k = 0; k < NCELL; k++) begin
            scr[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023));
            zr[k] = (scr[k] == 0);
        end
        do_start();
        feed(1'b1, -1);

        // row wrap: maxima at (0,31) then (1,0)
        for (int k = 0; k < NCELL; k++) begin
            scr[k] = int'($urandom_range(1, 50));
            zr[k] = 1'b0;
        end
        scr[DATABASE_LEN - 1] = 100;
        scr[DATABASE_LEN] = 150;
        do_start();
        feed(1'b1, -1);
        chk("wrap_max_row", int'(max_row), 1);
        chk("wrap_max_col", int'(max_col), 0);

        // reset mid-matrix, then a full matrix peaking at the last cell
        for (int k = 0; k < NCELL; k++) begin
            scr[k] = int'($urandom_range(0, 199));
            zr[k] = (scr[k] == 0);
        end
        scr[NCELL - 1] = 200;
        do_start();
        feed(1'b1, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("midrst");
        chk("midrst_queue", exp_q.size(), 0);
        pe_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_write", int'(tb_wr_en), 0);
        end
        pe_valid = 1'b0;
        do_start();
        feed(1'b1, -1);
        chk("peak_max_score", int'(max_score), 200);
        chk("peak_max_row", int'(max_row), QUERY_LEN - 1);
        chk("peak_max_col", int'(max_col), DATABASE_LEN - 1);

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
